// File: rtl/muldiv_arbiter.sv
// Two-port round-robin arbiter in front of a shared half-precision mul/div unit.
// Optional WAIT watchdog enabled by defining MULDIV_ARB_TIMEOUT_EN.
module muldiv_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] x0,
  input  logic [15:0] y0,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  input  logic        op0,
  input  logic        op1,
  output logic        ack0,
  output logic        ack1,
  output logic        rsp_valid0,
  output logic        rsp_valid1,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_ofuf,
  output logic [15:0] md_x,
  output logic [15:0] md_y,
  output logic        md_mulDiv,
  output logic        md_start,
  input  logic        md_done,
  input  logic [15:0] md_result,
  input  logic [1:0]  md_ofuf,
  output logic        busy
);

  // Handshake: a requester holds req_i and its operands until it sees the
  // one-cycle ack_i; the matching rsp_valid_i pulse later marks rsp_result/rsp_ofuf valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] opx_q, opx_d;
  logic [15:0] opy_q, opy_d;
  logic        opm_q, opm_d;
  logic [15:0] res_q, res_d;
  logic [1:0]  ofuf_q, ofuf_d;
  logic        pick;
`ifdef MULDIV_ARB_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    opx_d        = opx_q;
    opy_d        = opy_q;
    opm_d        = opm_q;
    res_d        = res_q;
    ofuf_d       = ofuf_q;
    pick         = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    rsp_valid0   = 1'b0;
    rsp_valid1   = 1'b0;
    md_start     = 1'b0;
`ifdef MULDIV_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that was not granted last time wins.
          pick         = (req0 && req1) ? ~last_grant_q : req1;
          grant_d      = pick;
          last_grant_d = pick;
          opx_d        = pick ? x1 : x0;
          opy_d        = pick ? y1 : y0;
          opm_d        = pick ? op1 : op0;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        ack0     = ~grant_q;
        ack1     = grant_q;
        md_start = 1'b1;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        // md_done may still be high from the previous operation here.
        state_d = S_WAIT;
`ifdef MULDIV_ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_WAIT: begin
        if (md_done) begin
          res_d   = md_result;
          ofuf_d  = md_ofuf;
          state_d = S_RESP;
        end
`ifdef MULDIV_ARB_TIMEOUT_EN
        else if (cnt_q == 8'd255) begin
          res_d   = 16'h7E00;
          ofuf_d  = 2'b11;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        rsp_valid0 = ~grant_q;
        rsp_valid1 = grant_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      opx_q        <= 16'd0;
      opy_q        <= 16'd0;
      opm_q        <= 1'b0;
      res_q        <= 16'd0;
      ofuf_q       <= 2'b00;
`ifdef MULDIV_ARB_TIMEOUT_EN
      cnt_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      opx_q        <= opx_d;
      opy_q        <= opy_d;
      opm_q        <= opm_d;
      res_q        <= res_d;
      ofuf_q       <= ofuf_d;
`ifdef MULDIV_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign md_x       = opx_q;
  assign md_y       = opy_q;
  assign md_mulDiv  = opm_q;
  assign rsp_result = res_q;
  assign rsp_ofuf   = ofuf_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Scoreboard bench for muldiv_arbiter with a behavioural mul/div stub whose
// results are hand-computed constants.
module tb_muldiv_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic        op0 = 1'b0, op1 = 1'b0;
  logic        ack0, ack1, rsp_valid0, rsp_valid1;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_ofuf;
  logic [15:0] md_x, md_y;
  logic        md_mulDiv, md_start;
  logic        md_done = 1'b0;
  logic [15:0] md_result = '0;
  logic [1:0]  md_ofuf = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // entry = {latency ack->rsp [8:0], port, result [15:0], ofuf [1:0]}
  localparam int W = 28;
  logic [W-1:0] exp_q[$];

  muldiv_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .op0(op0), .op1(op1),
    .ack0(ack0), .ack1(ack1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_result(rsp_result), .rsp_ofuf(rsp_ofuf),
    .md_x(md_x), .md_y(md_y), .md_mulDiv(md_mulDiv), .md_start(md_start),
    .md_done(md_done), .md_result(md_result), .md_ofuf(md_ofuf),
    .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int lat, input logic port,
                                      input logic [15:0] res, input logic [1:0] ofuf);
    logic [8:0] l;
    l = lat[8:0];
    return {l, port, res, ofuf};
  endfunction

  // mul/div stub: hand-computed half-precision results {ofuf, result}
  function automatic logic [17:0] md_model(input logic [15:0] a, input logic [15:0] b, input logic op);
    if (a == 16'h4F00 && b == 16'h0B80 && !op) return {2'b00, 16'h1E90};
    if (a == 16'hD98D && b == 16'h4F08 && !op) return {2'b00, 16'hECE0};
    if (a == 16'hD98D && b == 16'h4F08 &&  op) return {2'b00, 16'hC650};
    if (a == 16'h3C00 && b == 16'h0000 &&  op) return {2'b10, 16'h7C00};
    if (a == 16'h0400 && b == 16'h0400 && !op) return {2'b01, 16'h0000};
    return {2'b00, 16'hDEAD};
  endfunction

  int          stub_lat = 0;
  logic        stub_stale = 1'b0;
  logic        stub_kill = 1'b0;
  logic        stub_pend = 1'b0;
  logic        stub_hold = 1'b0;
  int          stub_cnt = 0;
  logic [17:0] stub_res = '0;

  // Done stays high until the next start; in stale mode it also survives the
  // cycle after start, so the arbiter sees an old done during SETTLE.
  always @(posedge clk) begin
    if (md_start) begin
      stub_pend <= 1'b1;
      stub_cnt  <= stub_lat;
      stub_res  <= md_model(md_x, md_y, md_mulDiv);
      stub_hold <= stub_stale;
      if (!stub_stale) md_done <= 1'b0;
    end else if (stub_hold) begin
      stub_hold <= 1'b0;
      md_done   <= 1'b0;
    end else if (stub_pend && !stub_kill) begin
      if (stub_cnt == 0) begin
        md_done              <= 1'b1;
        {md_ofuf, md_result} <= stub_res;
        stub_pend            <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // monitor: pops the scoreboard on every response pulse
  int   ack_cyc = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (ack0 || ack1) begin
      ack_cyc = cyc;
      check("ack_exclusive", {ack0, ack1} == 2'b11, 0);
      check("ack_with_start", md_start, 1);
      check("md_x_captured", md_x, ack1 ? x1 : x0);
      check("md_op_captured", md_mulDiv, ack1 ? op1 : op0);
    end
    if (md_start) check("md_start_one_cycle", prev_start, 0);
    prev_start = md_start;
    if (rsp_valid0 || rsp_valid1) begin
      check("rsp_exclusive", {rsp_valid0, rsp_valid1} == 2'b11, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got port %0d result %h, expected no response", rsp_valid1, rsp_result);
      end else begin
        e = exp_q.pop_front();
        check("rsp_port", rsp_valid1, e[18]);
        check("rsp_result", rsp_result, e[17:2]);
        check("rsp_ofuf", rsp_ofuf, e[1:0]);
        check("rsp_latency", cyc - ack_cyc, e[27:19]);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_acks", {ack0, ack1, md_start}, 0);
    check("rst_rsp_valid", {rsp_valid0, rsp_valid1}, 0);
    check("rst_md_ops", {md_x, md_y, md_mulDiv}, 0);
    check("rst_rsp_regs", {rsp_result, rsp_ofuf}, 0);
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic issue(input logic port, input logic [15:0] a, input logic [15:0] b, input logic op);
    int n;
    @(posedge clk); #1;
    if (port) begin x1 = a; y1 = b; op1 = op; req1 = 1'b1; end
    else      begin x0 = a; y0 = b; op0 = op; req0 = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? ack1 : ack0) && n < 3000);
    if (n >= 3000) check("ack_timeout", 0, 1);
    @(posedge clk); #1;
    if (port) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic hold_req1(input int grants, input logic [15:0] a, input logic [15:0] b, input logic op);
    int n, g;
    @(posedge clk); #1;
    x1 = a; y1 = b; op1 = op; req1 = 1'b1;
    n = 0; g = 0;
    while (g < grants && n < 3000) begin
      @(negedge clk);
      n++;
      if (ack1) g++;
    end
    if (n >= 3000) check("hold_ack_timeout", 0, 1);
    @(posedge clk); #1 req1 = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 3000);
    check("drain_timeout", n >= 3000, 0);
  endtask

  initial begin
    do_reset();

    // single port0 multiply, minimal latency
    stub_lat = 0;
    exp_q.push_back(mk(3, 1'b0, 16'h1E90, 2'b00));
    issue(1'b0, 16'h4F00, 16'h0B80, 1'b0);
    wait_idle();

    // both ports in the same cycle right after reset: port0 first
    do_reset();
    stub_lat = 1;
    exp_q.push_back(mk(4, 1'b0, 16'hECE0, 2'b00));
    exp_q.push_back(mk(4, 1'b1, 16'hC650, 2'b00));
    fork
      issue(1'b0, 16'hD98D, 16'h4F08, 1'b0);
      issue(1'b1, 16'hD98D, 16'h4F08, 1'b1);
    join
    wait_idle();

    // underflow flags through port1
    stub_lat = 3;
    exp_q.push_back(mk(6, 1'b1, 16'h0000, 2'b01));
    issue(1'b1, 16'h0400, 16'h0400, 1'b0);
    wait_idle();

    // stale done from the previous op stays high through LAUNCH and SETTLE
    stub_lat = 1;
    stub_stale = 1'b1;
    exp_q.push_back(mk(5, 1'b0, 16'h7C00, 2'b10));
    issue(1'b0, 16'h3C00, 16'h0000, 1'b1);
    wait_idle();
    stub_stale = 1'b0;

    // port1 holds req across two grants, port0 joins once: order 1,0,1
    do_reset();
    stub_lat = 2;
    exp_q.push_back(mk(5, 1'b1, 16'h1E90, 2'b00));
    exp_q.push_back(mk(5, 1'b0, 16'hECE0, 2'b00));
    exp_q.push_back(mk(5, 1'b1, 16'h1E90, 2'b00));
    fork
      hold_req1(2, 16'h4F00, 16'h0B80, 1'b0);
      begin
        repeat (2) @(posedge clk);
        issue(1'b0, 16'hD98D, 16'h4F08, 1'b0);
      end
    join
    wait_idle();

    // reset pulse while waiting on the unit aborts the operation
    stub_lat = 20;
    issue(1'b0, 16'h4F00, 16'h0B80, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_md_start", md_start, 0);
    check("abort_rsp_valid", {rsp_valid0, rsp_valid1}, 0);
    repeat (40) @(posedge clk);

    // after the abort, tie goes to port0 again
    stub_lat = 0;
    exp_q.push_back(mk(3, 1'b0, 16'h0000, 2'b01));
    exp_q.push_back(mk(3, 1'b1, 16'h1E90, 2'b00));
    fork
      issue(1'b0, 16'h0400, 16'h0400, 1'b0);
      issue(1'b1, 16'h4F00, 16'h0B80, 1'b0);
    join
    wait_idle();

`ifdef MULDIV_ARB_TIMEOUT_EN
    stub_kill = 1'b1;
    exp_q.push_back(mk(258, 1'b0, 16'h7E00, 2'b11));
    issue(1'b0, 16'h4F00, 16'h0B80, 1'b0);
    wait_idle();
    stub_kill = 1'b0;
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-low, sampled on clk rising edge.
REQ-003 SHALL have ports req0/req1, input, 1 each; requester i has an operation pending.
REQ-004 SHALL have ports x0/y0, x1/y1, input, 16 each; half-precision operands, held stable by requester while req_i=1 and ack_i=0.
REQ-005 SHALL have ports op0/op1, input, 1 each; 0=multiply, 1=divide (X/Y).
REQ-006 SHALL have ports ack0/ack1, output, 1 each; one-cycle grant pulse, operands captured that cycle.
REQ-007 SHALL have ports rsp_valid0/rsp_valid1, output, 1 each; one-cycle response pulse.
REQ-008 SHALL have ports rsp_result, output, 16, and rsp_ofuf, output, 2; shared response bus, meaningful only while a rsp_valid_i=1.
REQ-009 SHALL have ports md_x, md_y (output, 16), md_mulDiv (output, 1), md_start (output, 1, active-high start pulse to the mul/div unit's reset input).
REQ-010 SHALL have ports md_done (input, 1), md_result (input, 16), md_ofuf (input, 2) from the mul/div unit.
REQ-011 SHALL have port busy, output, 1; high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, LAUNCH, SETTLE, WAIT, RESP.
REQ-013 IDLE: if any req_i=1, SHALL grant per round-robin and go to LAUNCH; else stay IDLE.
REQ-014 Round-robin: one last_grant bit; both requesting -> grant the port not last granted; one requesting -> grant it; last_grant updated on each grant.
REQ-015 LAUNCH (exactly one cycle): ack_g=1, md_start=1, md_x/md_y/md_mulDiv driven from captured operands of granted port g; -> SETTLE.
REQ-016 Operands SHALL be captured into internal registers at IDLE->LAUNCH edge; md_x/md_y/md_mulDiv hold them until next grant.
REQ-017 SETTLE (exactly one cycle): md_done ignored (stale done from previous op); -> WAIT.
REQ-018 WAIT: on md_done=1 capture md_result/md_ofuf into rsp_result/rsp_ofuf and go to RESP; else stay.
REQ-019 RESP (exactly one cycle): rsp_valid_g=1 for granted port only; -> IDLE.
REQ-020 Latency: rsp_valid asserted the cycle after md_done is first sampled high in WAIT; minimum grant-to-response 4 cycles.
REQ-021 req_i sampled only in IDLE; a req held high through RESP SHALL be treated as a new request on return to IDLE.
REQ-022 ack_i and rsp_valid_i SHALL never be high for both ports in the same cycle.
REQ-023 rsp_result/rsp_ofuf SHALL hold last value outside RESP.

Reset
REQ-024 reset=0 SHALL force IDLE, last_grant=1 (port 0 wins first tie), all outputs 0, operand/result registers 0.
REQ-025 reset=0 mid-operation SHALL abort; no rsp_valid issued for the aborted op; md_start low.

Configuration
REQ-026 Macro MULDIV_ARB_TIMEOUT_EN defined: 8-bit counter cleared on entering WAIT, incremented each WAIT cycle; at count 255 without md_done -> RESP with rsp_result=16'h7E00, rsp_ofuf=2'b11.
REQ-027 Macro undefined: no counter; WAIT persists indefinitely until md_done.

Verification
REQ-028 Port0 only, x0=4F00, y0=0B80, op0=0 -> ack0 one cycle, md_start one cycle, rsp_valid0 with rsp_result=1E90, rsp_ofuf=00.
REQ-029 Both request same cycle after reset, port0 D98D*4F08 mul, port1 D98D/4F08 div -> port0 first (ECE0), then port1 (C650); never both rsp_valid high.
REQ-030 Port1 holds req continuously, port0 requests once -> grants alternate 1,0,1; port0 not starved.
REQ-031 md_done held high from prior op during LAUNCH/SETTLE -> no early response; rsp_valid only after SETTLE.
REQ-032 reset=0 for one cycle during WAIT -> busy=0 next cycle, no rsp_valid, next request served normally.
REQ-033 With MULDIV_ARB_TIMEOUT_EN, md_done tied 0 -> rsp_valid 256 cycles after entering WAIT, rsp_ofuf=11, rsp_result=7E00.
